// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct3 encodings,
// FSM state type and default widths.
package ex_muldiv_unit_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int CNT_W_DEF = 7;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_abs_neg.sv
// Combinational conditional two's-complement negate, used both for operand
// magnitudes and for result sign correction.
module muldiv_abs_neg #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, sharing a single 2*XLEN accumulator.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    state_e                r_state;
    state_e                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*XLEN-1:0]     r_acc;
    logic [XLEN-1:0]       r_b;
    logic [2:0]            r_op;
    logic [4:0]            r_rd;
    logic                  r_neg;
    logic [XLEN-1:0]       r_result;
    logic [4:0]            r_rd_out;

    logic                  w_accept;
    logic                  w_sgn_a;
    logic                  w_sgn_b;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [XLEN-1:0]       w_a_abs;
    logic [XLEN-1:0]       w_b_abs;
    logic                  w_ovf;
    logic                  w_fast;
    logic [2*XLEN-1:0]     w_fast_acc;
    logic                  w_sign;
    logic [XLEN:0]         w_add;
    logic [2*XLEN-1:0]     w_mul_nxt;
    logic [XLEN:0]         w_rem_sh;
    logic [XLEN:0]         w_diff;
    logic                  w_q_bit;
    logic [2*XLEN-1:0]     w_div_nxt;
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_div_raw;
    logic [XLEN-1:0]       w_div_res;
    logic [XLEN-1:0]       w_final;

    // Operand sign handling at accept time
    assign w_accept = (r_state == ST_IDLE) & start & ~flush;
    assign w_sgn_a  = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
    assign w_sgn_b  = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
    assign w_a_neg  = w_sgn_a & operand_a[XLEN-1];
    assign w_b_neg  = w_sgn_b & operand_b[XLEN-1];

    muldiv_abs_neg #(.W(XLEN)) u_abs_a (.i_val(operand_a), .i_neg(w_a_neg), .o_val(w_a_abs));
    muldiv_abs_neg #(.W(XLEN)) u_abs_b (.i_val(operand_b), .i_neg(w_b_neg), .o_val(w_b_abs));

    // Divide-by-zero and signed overflow resolve immediately; acc holds {rem, quot}
    assign w_ovf      = ((op == OP_DIV) | (op == OP_REM)) & (operand_a == XMIN) & (&operand_b);
    assign w_fast     = op[2] & ((operand_b == '0) | w_ovf);
    assign w_fast_acc = w_ovf ? {{XLEN{1'b0}}, operand_a} : {operand_a, {XLEN{1'b1}}};
    assign w_sign     = (op[2] & op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // Multiply step: conditionally add multiplicand to the high half, shift right
    assign w_add     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_nxt = {w_add, r_acc[XLEN-1:1]};

    // Divide step: shift dividend bit into remainder, subtract if it fits
    assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_q_bit   = ~w_diff[XLEN];
    assign w_div_nxt = {(w_q_bit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_q_bit};

    muldiv_abs_neg #(.W(2*XLEN)) u_neg_prod (.i_val(r_acc), .i_neg(r_neg), .o_val(w_prod));

    assign w_div_raw = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

    muldiv_abs_neg #(.W(XLEN)) u_neg_div (.i_val(w_div_raw), .i_neg(r_neg), .o_val(w_div_res));

    always_comb begin
        w_final = w_div_res;
        if (!r_op[2]) begin
            w_final = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_fast ? ST_DONE : ST_BUSY;
            ST_BUSY: if (r_cnt == CNT_ONE) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= op;
                r_rd  <= rd_in;
                r_b   <= w_b_abs;
                r_cnt <= CNT_INIT;
                r_neg <= w_fast ? 1'b0 : w_sign;
                r_acc <= w_fast ? w_fast_acc : {{XLEN{1'b0}}, w_a_abs};
            end else if (flush) begin
                r_cnt <= '0;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - CNT_ONE;
                r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
            end
            // A result in DONE is committed even if flush arrives that cycle
            if (r_state == ST_DONE) begin
                r_result <= w_final;
                r_rd_out <= r_rd;
            end
        end
    end

    assign stall  = ((r_state == ST_IDLE) & start) | (r_state == ST_BUSY);
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign result = done ? w_final : r_result;
    assign rd_out = done ? r_rd : r_rd_out;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed and random ops against a
// reference model through an expected-value queue, plus flush and reset cases.
module tb_ex_muldiv_unit;

    localparam int XLEN = 64;
    localparam logic [63:0] XMIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            start;
    logic [2:0]      op;
    logic [63:0]     operand_a;
    logic [63:0]     operand_b;
    logic [4:0]      rd_in;
    logic            stall;
    logic            busy;
    logic            done;
    logic [63:0]     result;
    logic [4:0]      rd_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];

    ex_muldiv_unit #(.XLEN(64), .CNT_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rd_in     (rd_in),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] f, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        r;
        logic               ovf;
        sa  = a;
        sb  = b;
        r   = '0;
        p   = '0;
        ovf = (a == XMIN) && (b == ONES);
        case (f)
            3'b000: begin p = {64'd0, a} * {64'd0, b}; r = p[63:0]; end
            3'b001: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            3'b010: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
            3'b011: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
            3'b100: begin
                if (b == 0) r = ONES;
                else if (ovf) r = a;
                else r = sa / sb;
            end
            3'b101: begin
                if (b == 0) r = ONES;
                else r = a / b;
            end
            3'b110: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else r = sa % sb;
            end
            default: begin
                if (b == 0) r = a;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    // Driver: called at a negedge, drives one op, waits for done, scores it.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          input bit poke_busy, input bit flush_in_done);
        int          lat;
        int          exp_lat;
        bit          seen;
        bit          stall_ok;
        bit          fast;
        logic [63:0] exp_res;
        logic [4:0]  exp_rd;
        fast    = f[2] && ((b == 0) || (!f[0] && (a == XMIN) && (b == ONES)));
        exp_lat = fast ? 1 : XLEN + 1;
        exp_q.push_back(ref_model(f, a, b));
        exp_rd_q.push_back(rd);

        op        = f;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        start     = 1'b1;
        #1;
        check_val({tag, "_stall_start"}, 64'(stall), 64'd1);
        @(negedge clk);
        start     = 1'b0;
        op        = 3'($urandom_range(0, 7));
        operand_a = {$urandom, $urandom};
        operand_b = {$urandom, $urandom};
        rd_in     = 5'($urandom_range(0, 31));
        lat       = 1;
        seen      = 0;
        stall_ok  = 1;
        while (lat < 200 && !seen) begin
            if (done) begin
                seen = 1;
            end else begin
                if (!stall || !busy) stall_ok = 0;
                start = (poke_busy && lat == 10);
                @(negedge clk);
                lat++;
            end
        end
        start   = 1'b0;
        exp_res = exp_q.pop_front();
        exp_rd  = exp_rd_q.pop_front();
        check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
        check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
        if (seen) begin
            check_val({tag, "_stall_done"}, 64'(stall), 64'd0);
            check_val({tag, "_result"}, result, exp_res);
            check_val({tag, "_rd"}, 64'(rd_out), 64'(exp_rd));
            if (flush_in_done) begin
                flush = 1'b1;
                #1;
                check_val({tag, "_done_under_flush"}, 64'(done), 64'd1);
            end
            @(negedge clk);
            flush = 1'b0;
            check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
            check_val({tag, "_result_hold"}, result, exp_res);
            check_val({tag, "_rd_hold"}, 64'(rd_out), 64'(exp_rd));
        end
    endtask

    initial begin
        int          quiet;
        logic [2:0]  rf;
        logic [63:0] ra;
        logic [63:0] rb;
        reset     = 1'b0;
        flush     = 1'b0;
        start     = 1'b0;
        op        = '0;
        operand_a = '0;
        operand_b = '0;
        rd_in     = '0;
        #2;
        check_val("reset_stall", 64'(stall), 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_result", result, 64'd0);
        check_val("reset_rd", 64'(rd_out), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul_7x6", 3'b000, 64'd7, 64'd6, 5'd5, 0, 0);

        // Flush mid-multiply: abort, no done, old result kept
        op = 3'b000; operand_a = 64'd9; operand_b = 64'd9; rd_in = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("flush_busy", 64'(busy), 64'd0);
        check_val("flush_stall", 64'(stall), 64'd0);
        check_val("flush_result", result, 64'd42);
        check_val("flush_rd", 64'(rd_out), 64'd5);
        quiet = 1;
        for (int i = 0; i < 70; i++) begin
            if (done || busy) quiet = 0;
            @(negedge clk);
        end
        check_val("flush_no_done", 64'(quiet), 64'd1);

        // flush together with start: nothing accepted
        op = 3'b101; operand_a = 64'd1; operand_b = 64'd1; rd_in = 5'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check_val("flush_start_busy", 64'(busy), 64'd0);
        check_val("flush_start_done", 64'(done), 64'd0);

        // Flush then a new op in the very next cycle
        op = 3'b000; operand_a = 64'd3; operand_b = 64'd5; rd_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        run_op("divu_100_7", 3'b101, 64'd100, 64'd7, 5'd11, 0, 0);

        run_op("mulh_m1m1", 3'b001, ONES, ONES, 5'd12, 1, 0);
        run_op("mulhu_ones", 3'b011, ONES, ONES, 5'd13, 0, 0);
        run_op("mulhsu_m1x2", 3'b010, ONES, 64'd2, 5'd14, 0, 0);
        run_op("div_m20_3", 3'b100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd15, 0, 0);
        run_op("rem_m20_3", 3'b110, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd16, 0, 1);
        run_op("remu_100_7", 3'b111, 64'd100, 64'd7, 5'd17, 0, 0);
        run_op("divu_5_0", 3'b101, 64'd5, 64'd0, 5'd18, 0, 0);
        run_op("rem_5_0", 3'b110, 64'd5, 64'd0, 5'd19, 0, 1);
        run_op("div_ovf", 3'b100, XMIN, ONES, 5'd20, 0, 0);
        run_op("rem_ovf", 3'b110, XMIN, ONES, 5'd21, 0, 0);
        run_op("mul_neg", 3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd22, 0, 0);

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            run_op("rand", rf, ra, rb, 5'($urandom_range(1, 31)), 0, 0);
        end

        // Asynchronous reset mid-divide
        op = 3'b100; operand_a = 64'hFFFF_FFFF_FFFF_FFEC; operand_b = 64'd3; rd_in = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_stall", 64'(stall), 64'd0);
        check_val("arst_busy", 64'(busy), 64'd0);
        check_val("arst_done", 64'(done), 64'd0);
        check_val("arst_result", result, 64'd0);
        check_val("arst_rd", 64'(rd_out), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("post_reset_div", 3'b100, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 5'd30, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
